// File: rtl/flux_pkg.sv
// Shared definitions for the multi-flux FIFO write path: tag sizing and the
// tagged-word layout (tag in the MSBs, payload in the LSBs).
package flux_pkg;

  function automatic int tag_width(input int flux);
    return $clog2(flux);
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FLUX       = 2;

  // Word as written into the FIFO for the default configuration.
  typedef struct packed {
    logic [tag_width(DEF_FLUX)-1:0] tag;
    logic [DEF_DATA_WIDTH-1:0]      payload;
  } flux_word_t;

endpackage

// File: rtl/flux_merge_arbiter_rr_arbiter.sv
// Round-robin arbiter with one-hot and binary grant; FLUX_MERGE_FIXED_PRIO_EN
// selects lowest-index-wins priority and removes the rotating pointer.
module rr_arbiter
  import flux_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = tag_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     request,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] base;

`ifdef FLUX_MERGE_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (int'(grant_idx) == N-1) ? '0 : grant_idx + 1'b1;
    end
  end

  assign base = rr_ptr;
`endif

  // Search upward from base, wrapping, and grant the first requester.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (enable && !found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/flux_merge_arbiter.sv
// Merges FLUX valid/ready streams into one tagged FIFO write per cycle.
// Build option FLUX_MERGE_FIXED_PRIO_EN switches arbitration to fixed priority.
module flux_merge_arbiter
  import flux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int TAG_WIDTH  = tag_width(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLUX-1:0]       in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [0:FLUX-1],
  output logic [FLUX-1:0]       in_ready,
  input  logic                  wr_full,
  output logic                  wr_write,
  output logic [WIDTH-1:0]      wr_din
);

  // Same bit split as flux_pkg::flux_word_t, sized by this instance.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] payload;
  } word_t;

  logic [DATA_WIDTH-1:0] hold_data [0:FLUX-1];
  logic [FLUX-1:0]       hold_valid;
  logic [FLUX-1:0]       grant;
  logic [TAG_WIDTH-1:0]  grant_idx;
  word_t                 word;

  rr_arbiter #(
    .N     (FLUX),
    .IDX_W (TAG_WIDTH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .request   (hold_valid),
    .enable    (!wr_full),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A slot draining this cycle can be refilled at the same edge.
  assign in_ready = ~hold_valid | grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      // NOTE: the holding registers are reset too, so wr_din and any debug
      // view of the slots start from a known zero rather than X.
      for (int i = 0; i < FLUX; i++) hold_data[i] <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= in_data[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign wr_write = |grant;

  always_comb begin
    word.tag     = grant_idx;
    word.payload = hold_data[grant_idx];
    wr_din       = wr_write ? WIDTH'(word) : '0;
  end

endmodule

// File: tb/tb_flux_merge_arbiter.sv
// Self-checking bench for flux_merge_arbiter (DATA_WIDTH=8, FLUX=2): vector
// table with a write scoreboard, plus reset and async-reset sequences.
module tb_flux_merge_arbiter;
  import flux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid;
  logic [7:0] in_data [0:1];
  logic [1:0] in_ready;
  logic       wr_full;
  logic       wr_write;
  logic [8:0] wr_din;

  int n_vec  = 0;
  int n_miss = 0;

  flux_word_t exp_q [$];

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       full;
    logic [1:0] exp_ready;
    logic       exp_write;
    flux_word_t exp_din;
  } vec_t;

  vec_t tbl [$];

  flux_merge_arbiter #(.DATA_WIDTH(8), .FLUX(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_full  (wr_full),
    .wr_write (wr_write),
    .wr_din   (wr_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                              input logic f, input logic [1:0] er, input logic ew,
                              input logic tag, input logic [7:0] pay);
    vec_t r;
    r.valid = v; r.d0 = d0; r.d1 = d1; r.full = f;
    r.exp_ready = er; r.exp_write = ew;
    r.exp_din.tag = tag; r.exp_din.payload = pay;
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic f);
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    wr_full    = f;
  endtask

  initial begin
`ifdef FLUX_MERGE_FIXED_PRIO_EN
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 0, 8'h00));
    tbl.push_back(mk(2'b11, 8'h30, 8'h40, 0, 2'b11, 0, 0, 8'h00));
    tbl.push_back(mk(2'b11, 8'h31, 8'h40, 0, 2'b01, 1, 0, 8'h30));
    tbl.push_back(mk(2'b11, 8'h32, 8'h40, 0, 2'b01, 1, 0, 8'h31));
    tbl.push_back(mk(2'b10, 8'h33, 8'h40, 0, 2'b01, 1, 0, 8'h32));
    tbl.push_back(mk(2'b00, 8'h33, 8'h40, 0, 2'b11, 1, 1, 8'h40));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 0, 8'h00));
`else
    // single stream
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 0, 8'h00));
    tbl.push_back(mk(2'b10, 8'h00, 8'hA5, 0, 2'b11, 0, 0, 8'h00));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 1, 1, 8'hA5));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 0, 8'h00));
    // both streams continuously valid: tags alternate
    tbl.push_back(mk(2'b11, 8'h10, 8'h20, 0, 2'b11, 0, 0, 8'h00));
    tbl.push_back(mk(2'b11, 8'h11, 8'h21, 0, 2'b01, 1, 0, 8'h10));
    tbl.push_back(mk(2'b11, 8'h12, 8'h21, 0, 2'b10, 1, 1, 8'h20));
    tbl.push_back(mk(2'b11, 8'h12, 8'h22, 0, 2'b01, 1, 0, 8'h11));
    tbl.push_back(mk(2'b11, 8'h13, 8'h22, 0, 2'b10, 1, 1, 8'h21));
    // full for 5 cycles; in_data wiggles while not ready
    tbl.push_back(mk(2'b11, 8'h13, 8'h23, 1, 2'b00, 0, 0, 8'h00));
    tbl.push_back(mk(2'b11, 8'hEE, 8'hDD, 1, 2'b00, 0, 0, 8'h00));
    tbl.push_back(mk(2'b11, 8'h77, 8'h88, 1, 2'b00, 0, 0, 8'h00));
    tbl.push_back(mk(2'b01, 8'hC3, 8'h3C, 1, 2'b00, 0, 0, 8'h00));
    tbl.push_back(mk(2'b10, 8'h5A, 8'hA5, 1, 2'b00, 0, 0, 8'h00));
    // resume: stream 0 first, held data intact
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b01, 1, 0, 8'h12));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 1, 1, 8'h22));
    tbl.push_back(mk(2'b00, 8'h00, 8'h00, 0, 2'b11, 0, 0, 8'h00));
`endif

    rst = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_ready", 16'(in_ready), 16'h3);
      check("idle_write", 16'(wr_write), 16'h0);
      check("idle_din",   16'(wr_din),   16'h0);
    end

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].valid, tbl[i].d0, tbl[i].d1, tbl[i].full);
      if (tbl[i].exp_write) exp_q.push_back(tbl[i].exp_din);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), 16'(in_ready), 16'(tbl[i].exp_ready));
      check($sformatf("v%0d_write", i), 16'(wr_write), 16'(tbl[i].exp_write));
      if (wr_write) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_unexpected_write", i), 16'(wr_din), 16'h0);
        end else begin
          check($sformatf("v%0d_din", i), 16'(wr_din), 16'(exp_q.pop_front()));
        end
      end else begin
        check($sformatf("v%0d_din_idle", i), 16'(wr_din), 16'h0);
      end
    end
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    // Async reset with both holds full: stale words must never be written.
    @(posedge clk);
    #1 drive(2'b11, 8'h55, 8'h66, 1'b1);
    @(posedge clk);
    #1 drive(2'b00, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check("pre_rst_ready", 16'(in_ready), 16'h0);
    check("pre_rst_write", 16'(wr_write), 16'h0);
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 16'(in_ready), 16'h3);
    check("rst_write", 16'(wr_write), 16'h0);
    check("rst_din",   16'(wr_din),   16'h0);
    wr_full = 1'b0;
    #1;
    check("rst_nofull_write", 16'(wr_write), 16'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_write", 16'(wr_write), 16'h0);
      check("post_rst_din",   16'(wr_din),   16'h0);
      check("post_rst_ready", 16'(in_ready), 16'h3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
